// File: rtl/timer_count_ctrl_if.sv
// ---------------------------------------------------------------------------
// timer_count_ctrl_if
//   Register-side bundle between the APB register file and the timer count
//   controller. The register block drives TDR/TCR (master); the controller
//   returns the count, wrap pulses and status (slave).
//   Signals:
//     reg_TDR     CNT_W  reload value
//     reg_TCR     8      control: [7] LOAD, [5] DOWN, [4] EN, [1:0] CKS
//     cnt         CNT_W  current counter value
//     tmr_ovf     1      one-cycle pulse on up-count wrap max->0
//     tmr_udf     1      one-cycle pulse on down-count wrap 0->max
//     tmr_run     1      high while the controller is in RUN
//     ctrl_state  2      controller state (00 IDLE, 01 LOAD, 10 RUN)
// ---------------------------------------------------------------------------
interface timer_count_ctrl_if #(
  parameter int unsigned CNT_W = 8
);

  logic [CNT_W-1:0] reg_TDR;
  logic [7:0]       reg_TCR;
  logic [CNT_W-1:0] cnt;
  logic             tmr_ovf;
  logic             tmr_udf;
  logic             tmr_run;
  logic [1:0]       ctrl_state;

  modport master (
    output reg_TDR,
    output reg_TCR,
    input  cnt,
    input  tmr_ovf,
    input  tmr_udf,
    input  tmr_run,
    input  ctrl_state
  );

  modport slave (
    input  reg_TDR,
    input  reg_TCR,
    output cnt,
    output tmr_ovf,
    output tmr_udf,
    output tmr_run,
    output ctrl_state
  );

endinterface

// File: rtl/timer_count_ctrl.sv
// ---------------------------------------------------------------------------
// timer_count_ctrl
//   Sequencing controller for the timer counter. Decodes the TCR control
//   fields, divides PCLK by 2/4/8/16, loads the counter from TDR and counts
//   it up or down, emitting one-cycle wrap pulses for the TSR flag logic.
//   Ports:
//     PCLK     in  system clock, rising edge
//     PRESETn  in  asynchronous active-low reset
//     bus      timer_count_ctrl_if.slave (TDR/TCR in; cnt, tmr_ovf,
//              tmr_udf, tmr_run, ctrl_state out -- all registered)
// ---------------------------------------------------------------------------
module timer_count_ctrl #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PRESC_W = 4
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  timer_count_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_ILL  = 2'b11
  } state_e;

  state_e             state_q, state_next;
  logic [CNT_W-1:0]   cnt_q, cnt_next;
  logic [PRESC_W-1:0] presc_q, presc_next;
  logic [1:0]         cks_q;
  logic               ovf_q, ovf_next;
  logic               udf_q, udf_next;
  logic               run_q, run_next;

  logic               tcr_load;
  logic               tcr_down;
  logic               tcr_en;
  logic [1:0]         tcr_cks;
  logic [PRESC_W-1:0] div_max;
  logic               tick;
  logic               unused_tcr;

  // TCR field decode; bits [6] and [3:2] carry no function here
  assign tcr_load   = bus.reg_TCR[7];
  assign tcr_down   = bus.reg_TCR[5];
  assign tcr_en     = bus.reg_TCR[4];
  assign tcr_cks    = bus.reg_TCR[1:0];
  assign unused_tcr = ^{bus.reg_TCR[6], bus.reg_TCR[3:2]};

  // Terminal prescaler value N-1 for N = 2^(CKS+1)
  always_comb begin
    div_max = '0;
    case (tcr_cks)
      2'd0:    div_max = PRESC_W'(1);
      2'd1:    div_max = PRESC_W'(3);
      2'd2:    div_max = PRESC_W'(7);
      default: div_max = PRESC_W'(15);
    endcase
  end

  // Next-state, prescaler, counter and pulse logic
  always_comb begin
    state_next = state_q;
    cnt_next   = cnt_q;
    presc_next = presc_q;
    ovf_next   = 1'b0;
    udf_next   = 1'b0;
    tick       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        presc_next = '0;
        if (tcr_en) state_next = ST_RUN;
      end

      ST_LOAD: begin
        cnt_next   = bus.reg_TDR;
        presc_next = '0;
        state_next = tcr_en ? ST_RUN : ST_IDLE;
      end

      ST_RUN: begin
        if (!tcr_en) begin
          // Pause: counter holds, re-entry restarts the divide from zero
          state_next = ST_IDLE;
          presc_next = '0;
        end else if (tcr_cks != cks_q) begin
          // Divider ratio changed: restart the divide, suppress this tick
          presc_next = '0;
        end else if (presc_q == div_max) begin
          presc_next = '0;
          tick       = 1'b1;
        end else begin
          presc_next = presc_q + PRESC_W'(1);
        end

        if (tick) begin
          if (tcr_down) begin
            if (cnt_q == '0) begin
              cnt_next = CNT_MAX;
              udf_next = 1'b1;
            end else begin
              cnt_next = cnt_q - CNT_W'(1);
            end
          end else begin
            if (cnt_q == CNT_MAX) begin
              cnt_next = '0;
              ovf_next = 1'b1;
            end else begin
              cnt_next = cnt_q + CNT_W'(1);
            end
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        presc_next = '0;
      end
    endcase

    // LOAD overrides EN and any same-cycle tick, dropping its pulse
    if (tcr_load && (state_q != ST_ILL)) begin
      state_next = ST_LOAD;
      cnt_next   = bus.reg_TDR;
      presc_next = '0;
      ovf_next   = 1'b0;
      udf_next   = 1'b0;
    end

    run_next = (state_next == ST_RUN);
  end

  // State and datapath registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      presc_q <= '0;
      cks_q   <= 2'b00;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_next;
      cnt_q   <= cnt_next;
      presc_q <= presc_next;
      cks_q   <= tcr_cks;
      ovf_q   <= ovf_next;
      udf_q   <= udf_next;
      run_q   <= run_next;
    end
  end

  assign bus.cnt        = cnt_q;
  assign bus.tmr_ovf    = ovf_q;
  assign bus.tmr_udf    = udf_q;
  assign bus.tmr_run    = run_q;
  assign bus.ctrl_state = 2'(state_q);

endmodule

// File: tb/tb_timer_count_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_count_ctrl
//   Directed bench for timer_count_ctrl: load/run sequencing, prescaler
//   latency, wrap pulses, pause/resume, LOAD priority, CKS change and
//   asynchronous reset. Inputs change 1 time unit after a rising edge and
//   outputs are sampled at that point.
// ---------------------------------------------------------------------------
module tb_timer_count_ctrl;

  logic PCLK;
  logic PRESETn;
  int   checks;
  int   errors;

  timer_count_ctrl_if #(.CNT_W(8)) bus ();

  timer_count_ctrl #(
    .CNT_W   (8),
    .PRESC_W (4)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Advance n rising edges, stopping 1 unit past the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Load TDR then enable with the given TCR (LOAD bit clear)
  task automatic load_then_run(input logic [7:0] tdr, input logic [7:0] tcr_load,
                               input logic [7:0] tcr_run);
    bus.reg_TDR = tdr;
    bus.reg_TCR = tcr_load;
    step(1);
    bus.reg_TCR = tcr_run;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    PRESETn     = 1'b0;
    bus.reg_TDR = 8'h00;
    bus.reg_TCR = 8'h00;
    step(2);

    // Reset values
    chk("rst_cnt",   32'(bus.cnt),        32'h00);
    chk("rst_ovf",   32'(bus.tmr_ovf),    32'h0);
    chk("rst_udf",   32'(bus.tmr_udf),    32'h0);
    chk("rst_run",   32'(bus.tmr_run),    32'h0);
    chk("rst_state", 32'(bus.ctrl_state), 32'h0);
    PRESETn = 1'b1;
    step(2);
    chk("idle_hold_state", 32'(bus.ctrl_state), 32'h0);

    // 1: load 0x10, count up by 2
    bus.reg_TDR = 8'h10;
    bus.reg_TCR = 8'h80;
    step(1);
    chk("t1_load_state", 32'(bus.ctrl_state), 32'h1);
    chk("t1_load_cnt",   32'(bus.cnt),        32'h10);
    bus.reg_TCR = 8'h10;
    step(1);
    chk("t1_run_state", 32'(bus.ctrl_state), 32'h2);
    chk("t1_run_flag",  32'(bus.tmr_run),    32'h1);
    chk("t1_cnt_e0",    32'(bus.cnt),        32'h10);
    step(1);
    chk("t1_cnt_e1",    32'(bus.cnt),        32'h10);
    step(1);
    chk("t1_cnt_e2",    32'(bus.cnt),        32'h11);
    step(2);
    chk("t1_cnt_e4",    32'(bus.cnt),        32'h12);

    // 2: up-count wrap FE,FF,00 with one-cycle ovf
    load_then_run(8'hFE, 8'h80, 8'h10);
    chk("t2_cnt_e0", 32'(bus.cnt), 32'hFE);
    step(2);
    chk("t2_cnt_ff", 32'(bus.cnt),     32'hFF);
    chk("t2_ovf_ff", 32'(bus.tmr_ovf), 32'h0);
    step(1);
    chk("t2_cnt_e3", 32'(bus.cnt),     32'hFF);
    step(1);
    chk("t2_cnt_00", 32'(bus.cnt),     32'h00);
    chk("t2_ovf_hi", 32'(bus.tmr_ovf), 32'h1);
    chk("t2_udf_lo", 32'(bus.tmr_udf), 32'h0);
    step(1);
    chk("t2_ovf_clr", 32'(bus.tmr_ovf), 32'h0);
    chk("t2_cnt_e5",  32'(bus.cnt),     32'h00);
    step(1);
    chk("t2_cnt_01",  32'(bus.cnt),     32'h01);
    chk("t2_ovf_e6",  32'(bus.tmr_ovf), 32'h0);

    // 3: down-count divide-by-16 with underflow
    load_then_run(8'h01, 8'h83, 8'h33);
    step(15);
    chk("t3_cnt_e15", 32'(bus.cnt), 32'h01);
    step(1);
    chk("t3_cnt_e16", 32'(bus.cnt),     32'h00);
    chk("t3_udf_e16", 32'(bus.tmr_udf), 32'h0);
    step(15);
    chk("t3_cnt_e31", 32'(bus.cnt), 32'h00);
    step(1);
    chk("t3_cnt_ff",  32'(bus.cnt),     32'hFF);
    chk("t3_udf_hi",  32'(bus.tmr_udf), 32'h1);
    chk("t3_ovf_lo",  32'(bus.tmr_ovf), 32'h0);
    step(1);
    chk("t3_udf_clr", 32'(bus.tmr_udf), 32'h0);
    chk("t3_cnt_hold", 32'(bus.cnt),    32'hFF);

    // 4: pause at 0x40 for 20 cycles, then resume
    load_then_run(8'h3F, 8'h80, 8'h10);
    step(2);
    chk("t4_cnt_40", 32'(bus.cnt), 32'h40);
    bus.reg_TCR = 8'h00;
    step(1);
    chk("t4_pause_state", 32'(bus.ctrl_state), 32'h0);
    chk("t4_pause_run",   32'(bus.tmr_run),    32'h0);
    step(19);
    chk("t4_pause_cnt",   32'(bus.cnt),        32'h40);
    bus.reg_TCR = 8'h10;
    step(1);
    chk("t4_resume_run", 32'(bus.tmr_run), 32'h1);
    step(1);
    chk("t4_resume_e1",  32'(bus.cnt),     32'h40);
    step(1);
    chk("t4_resume_e2",  32'(bus.cnt),     32'h41);

    // 5a: LOAD on the tick edge at 0xFF drops the wrap
    load_then_run(8'hFE, 8'h80, 8'h10);
    step(3);
    chk("t5_cnt_ff", 32'(bus.cnt), 32'hFF);
    bus.reg_TDR = 8'h20;
    bus.reg_TCR = 8'h90;
    step(1);
    chk("t5_load_cnt",   32'(bus.cnt),        32'h20);
    chk("t5_load_ovf",   32'(bus.tmr_ovf),    32'h0);
    chk("t5_load_state", 32'(bus.ctrl_state), 32'h1);

    // 5b: CKS 0->3 mid-run restarts the divide
    bus.reg_TCR = 8'h10;
    step(1);
    step(2);
    chk("t5_cnt_21", 32'(bus.cnt), 32'h21);
    step(1);
    bus.reg_TCR = 8'h13;
    step(1);
    chk("t5_cks_chg", 32'(bus.cnt), 32'h21);
    step(15);
    chk("t5_cks_e15", 32'(bus.cnt), 32'h21);
    step(1);
    chk("t5_cks_e16", 32'(bus.cnt), 32'h22);

    // 6: asynchronous reset mid-RUN at 0x7F
    load_then_run(8'h7E, 8'h80, 8'h10);
    step(2);
    chk("t6_cnt_7f", 32'(bus.cnt), 32'h7F);
    step(1);
    PRESETn = 1'b0;
    #1;
    chk("t6_rst_cnt",   32'(bus.cnt),        32'h00);
    chk("t6_rst_state", 32'(bus.ctrl_state), 32'h0);
    chk("t6_rst_run",   32'(bus.tmr_run),    32'h0);
    chk("t6_rst_ovf",   32'(bus.tmr_ovf),    32'h0);
    step(1);
    bus.reg_TCR = 8'h00;
    PRESETn     = 1'b1;
    step(3);
    chk("t6_idle_state", 32'(bus.ctrl_state), 32'h0);
    chk("t6_idle_cnt",   32'(bus.cnt),        32'h00);
    bus.reg_TCR = 8'h10;
    step(1);
    chk("t6_en_state", 32'(bus.ctrl_state), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
